// File: rtl/mcp_arb_pkg.sv
// rtl/mcp_arb_pkg.sv - shared types and helpers for the MCP send arbiter
//
// Contents:
//   mcp_arb_state_t  arbiter FSM states (IDLE, ISSUE, BUSY)
//   MCP_PACK_W       width of the generic pack helper's operands/result
//   mcp_pack_word    {id, payload} concatenation for any payload width
package mcp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } mcp_arb_state_t;

  localparam int MCP_PACK_W = 64;

  // Width-generic concatenation: the caller zero-extends id/payload into
  // MCP_PACK_W bits and truncates the result to ID_WIDTH+DATA_WIDTH.
  function automatic logic [MCP_PACK_W-1:0] mcp_pack_word(
    input logic [MCP_PACK_W-1:0] id,
    input logic [MCP_PACK_W-1:0] payload,
    input int                    data_width
  );
    return (id << data_width) | payload;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant selection
//
// Ports:
//   req    in   NUM_REQ    request vector
//   ptr    in   ID_WIDTH   index of the last winner; search starts at ptr+1
//   grant  out  NUM_REQ    one-hot grant (all zero when no request)
//   idx    out  ID_WIDTH   index of the granted requester
//   valid  out  1          at least one request is set
module rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] idx,
  output logic                valid
);

  logic [ID_WIDTH-1:0] cand;

  // Walk ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the first set request wins,
  // so the previous winner is considered last.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcp_send_arbiter.sv
// rtl/mcp_send_arbiter.sv - round-robin sharing of one MCP clk_a send port
//
// Ports:
//   clk        in   1                    clock (MCP clk_a domain)
//   reset      in   1                    async reset, active high
//   req        in   NUM_REQ              per-requester send request (level)
//   req_data   in   NUM_REQ*DATA_WIDTH   payloads, requester i at slice i
//   req_ack    out  NUM_REQ              one-hot pulse: word i accepted
//   mcp_ready  in   1                    MCP a_ready
//   mcp_send   out  1                    MCP a_send, single-cycle pulse
//   mcp_data   out  ID_WIDTH+DATA_WIDTH  MCP a_datain = {id, payload}
//   stall      out  1                    sticky: crossing busy >= TIMEOUT
module mcp_send_arbiter
  import mcp_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  input  logic                           mcp_ready,
  output logic                           mcp_send,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] mcp_data,
  output logic                           stall
);

  localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

  mcp_arb_state_t state_q, state_d;

  // ptr_q always equals the id of the latched word, so it doubles as the
  // index for req_ack.
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [ID_WIDTH-1:0]   arb_idx;
  logic                  arb_valid;
  logic [DATA_WIDTH-1:0] sel_payload;
  logic                  load_word;
  logic                  fire;
  logic [WD_WIDTH-1:0]   wd_cnt_q;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_payload = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_payload = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // mcp_send is high exactly in the first BUSY cycle, which gives the
  // one-cycle minimum dwell while the MCP's tx_busy rises.
  always_comb begin
    state_d   = state_q;
    load_word = 1'b0;
    fire      = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid && mcp_ready) begin
          load_word = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (mcp_ready) begin
          fire    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mcp_ready && !mcp_send) begin
          if (arb_valid) begin
            load_word = 1'b1;
            state_d   = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
      mcp_data <= '0;
      mcp_send <= 1'b0;
      req_ack  <= '0;
    end else begin
      mcp_send <= fire;
      req_ack  <= fire ? (NUM_REQ'(1) << ptr_q) : '0;
      if (load_word) begin
        ptr_q    <= arb_idx;
        mcp_data <= (ID_WIDTH + DATA_WIDTH)'(mcp_pack_word(
                      MCP_PACK_W'(arb_idx), MCP_PACK_W'(sel_payload), DATA_WIDTH));
      end
    end
  end

  // Watchdog: counts BUSY cycles with the MCP not ready, saturating at
  // TIMEOUT; stall latches on the cycle the count reaches TIMEOUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      stall    <= 1'b0;
    end else if (state_q != BUSY) begin
      wd_cnt_q <= '0;
    end else if (!mcp_ready && wd_cnt_q != WD_WIDTH'(TIMEOUT)) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
      if (wd_cnt_q == WD_WIDTH'(TIMEOUT - 1)) stall <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcp_send_arbiter.sv
// tb/tb_mcp_send_arbiter.sv - self-checking bench for mcp_send_arbiter
module tb_mcp_send_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ack;
  logic            mcp_ready;
  logic            mcp_send;
  logic [IW+DW-1:0] mcp_data;
  logic            stall;

  logic rdy_m = 1'b1;
  logic force_low = 1'b0;
  int   mcp_cnt = 0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign mcp_ready = rdy_m & ~force_low;

  mcp_send_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .mcp_ready (mcp_ready),
    .mcp_send  (mcp_send),
    .mcp_data  (mcp_data),
    .stall     (stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MCP sender model: a_ready drops right after a send and returns 6 cycles later.
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      rdy_m   = 1'b1;
      mcp_cnt = 0;
    end else if (mcp_send) begin
      rdy_m   = 1'b0;
      mcp_cnt = 6;
    end else if (mcp_cnt > 0) begin
      mcp_cnt--;
      if (mcp_cnt == 0) rdy_m = 1'b1;
    end
  end

  // Transaction-level reference: a chosen word waits for ready, is sent,
  // then the crossing is occupied until ready returns (never in the send
  // cycle itself); a new choice is made whenever the port is free.
  logic         m_pending, m_inflight, m_fresh;
  int           m_last, m_id, m_wd;
  logic         exp_send, exp_stall;
  logic [N-1:0] exp_ack;
  logic [IW+DW-1:0] exp_data;

  task automatic model_choose();
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (!m_pending && req[c]) begin
        m_pending = 1'b1;
        m_id      = c;
        m_last    = c;
        exp_data  = {IW'(c), req_data[c*DW +: DW]};
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pending = 0; m_inflight = 0; m_fresh = 0;
      m_last = N - 1; m_id = 0; m_wd = 0;
      exp_send = 0; exp_stall = 0; exp_ack = '0; exp_data = '0;
    end else begin
      exp_send = 1'b0;
      exp_ack  = '0;
      if (m_pending) begin
        if (mcp_ready) begin
          exp_send   = 1'b1;
          exp_ack    = N'(1) << m_id;
          m_pending  = 1'b0;
          m_inflight = 1'b1;
          m_fresh    = 1'b1;
        end
      end else if (m_inflight) begin
        if (!m_fresh && mcp_ready) begin
          m_inflight = 1'b0;
          model_choose();
        end else if (!mcp_ready) begin
          if (m_wd < TO) m_wd++;
          if (m_wd >= TO) exp_stall = 1'b1;
        end
        m_fresh = 1'b0;
      end else if (mcp_ready) begin
        model_choose();
      end
      if (!m_inflight) m_wd = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("send", 32'(mcp_send), 32'(exp_send));
      check("ack", 32'(req_ack), 32'(exp_ack));
      check("data", 32'(mcp_data), 32'(exp_data));
      check("stall", 32'(stall), 32'(exp_stall));
    end
  end

  task automatic wait_send(input string name, input int budget, output int id);
    id = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (mcp_send) begin
        id = int'(mcp_data[IW+DW-1:DW]);
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s: no mcp_send within %0d cycles", name, budget);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    force_low = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int id;
  int cnt;
  int exp_ids [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    // 1: reset values, then single request latency and tagging
    do_reset();
    check("rst_send", 32'(mcp_send), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_data", 32'(mcp_data), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    req_data[0*DW +: DW] = 8'hA5;
    req = 4'b0001;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t1_send", 32'(mcp_send), 32'd1);
    check("t1_data", 32'(mcp_data), 32'h0A5);
    check("t1_ack", 32'(req_ack), 32'b0001);
    req = '0;
    repeat (12) @(negedge clk);

    // 2: all requesters active, fair rotation
    do_reset();
    req_data = 32'h44_33_22_11;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      wait_send("t2_wait", 30, id);
      check("t2_id", 32'(id), 32'(exp_ids[i]));
      check("t2_ack", 32'(req_ack), 32'(4'b0001 << exp_ids[i]));
    end
    req = '0;
    repeat (12) @(negedge clk);

    // 3: pointer at 1, requests 1 and 3 -> 3 first, then 1
    do_reset();
    req = 4'b0010;
    wait_send("t3_prep", 20, id);
    check("t3_prep_id", 32'(id), 32'd1);
    req = '0;
    repeat (12) @(negedge clk);
    req = 4'b1010;
    wait_send("t3_first", 20, id);
    check("t3_first_id", 32'(id), 32'd3);
    wait_send("t3_second", 30, id);
    check("t3_second_id", 32'(id), 32'd1);
    req = '0;
    repeat (12) @(negedge clk);

    // 4: crossing stuck after a send -> stall at BUSY cycle 64
    do_reset();
    req = 4'b0001;
    wait_send("t4_send", 20, id);
    force_low = 1'b1;
    req = 4'b0010;
    cnt = 0;
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      if (mcp_send) cnt++;
      if (j == 63) check("t4_stall_63", 32'(stall), 32'd0);
      if (j == 64) check("t4_stall_64", 32'(stall), 32'd1);
    end
    check("t4_no_send", 32'(cnt), 32'd0);
    force_low = 1'b0;
    wait_send("t4_resume", 20, id);
    check("t4_resume_id", 32'(id), 32'd1);
    check("t4_stall_kept", 32'(stall), 32'd1);
    req = '0;
    repeat (12) @(negedge clk);

    // 5: reset while BUSY clears everything at once; pointer back to 3
    req = 4'b0001;
    wait_send("t5_send", 20, id);
    check("t5_pre_id", 32'(id), 32'd0);
    reset = 1'b1;
    req = '0;
    #1;
    check("t5_send0", 32'(mcp_send), 32'd0);
    check("t5_ack0", 32'(req_ack), 32'd0);
    check("t5_data0", 32'(mcp_data), 32'd0);
    check("t5_stall0", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req_data[2*DW +: DW] = 8'h3C;
    req = 4'b0100;
    wait_send("t5_after", 20, id);
    check("t5_after_data", 32'(mcp_data), 32'h23C);
    req = '0;
    repeat (12) @(negedge clk);

    // 6: request dropped while the latched word waits for ready
    do_reset();
    req_data[0*DW +: DW] = 8'h5A;
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    force_low = 1'b1;
    req = '0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("t6_hold", 32'(mcp_send), 32'd0);
    end
    force_low = 1'b0;
    wait_send("t6_send", 5, id);
    check("t6_data", 32'(mcp_data), 32'h05A);
    check("t6_ack", 32'(req_ack), 32'b0001);
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (mcp_send) cnt++;
    end
    check("t6_no_repeat", 32'(cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
